// File: rtl/axi3_slave_mem_if.sv
// AXI3 burst bus bundle between a master and the axi3_slave_mem responder.
// Ports: AR/R, AW/W/B channels; master drives requests, slave drives responses.
interface axi3_slave_mem_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8
);
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    logic [AXI_WIDTH_AD-1:0] S_ARADDR;
    logic [AXI_WIDTH_ID-1:0] S_ARID;
    logic [7:0]              S_ARLEN;
    logic [2:0]              S_ARSIZE;
    logic [1:0]              S_ARBURST;
    logic [1:0]              S_ARLOCK;
    logic [3:0]              S_ARCACHE;
    logic [2:0]              S_ARPROT;
    logic                    S_RVALID;
    logic                    S_RREADY;
    logic [AXI_WIDTH_DA-1:0] S_RDATA;
    logic [AXI_WIDTH_ID-1:0] S_RID;
    logic [1:0]              S_RRESP;
    logic                    S_RLAST;
    logic                    S_RUSER;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    logic [AXI_WIDTH_AD-1:0] S_AWADDR;
    logic [AXI_WIDTH_ID-1:0] S_AWID;
    logic [7:0]              S_AWLEN;
    logic [2:0]              S_AWSIZE;
    logic [1:0]              S_AWBURST;
    logic [1:0]              S_AWLOCK;
    logic [3:0]              S_AWCACHE;
    logic [2:0]              S_AWPROT;
    logic                    S_WVALID;
    logic                    S_WREADY;
    logic [AXI_WIDTH_DA-1:0] S_WDATA;
    logic [AXI_WIDTH_DS-1:0] S_WSTRB;
    logic                    S_WLAST;
    logic [AXI_WIDTH_ID-1:0] S_WID;
    logic                    S_BVALID;
    logic                    S_BREADY;
    logic [AXI_WIDTH_ID-1:0] S_BID;
    logic [1:0]              S_BRESP;
    logic                    S_BUSER;

    modport master (
        output S_ARVALID, S_ARADDR, S_ARID, S_ARLEN, S_ARSIZE, S_ARBURST,
        output S_ARLOCK, S_ARCACHE, S_ARPROT,
        input  S_ARREADY,
        input  S_RVALID, S_RDATA, S_RID, S_RRESP, S_RLAST, S_RUSER,
        output S_RREADY,
        output S_AWVALID, S_AWADDR, S_AWID, S_AWLEN, S_AWSIZE, S_AWBURST,
        output S_AWLOCK, S_AWCACHE, S_AWPROT,
        input  S_AWREADY,
        output S_WVALID, S_WDATA, S_WSTRB, S_WLAST, S_WID,
        input  S_WREADY,
        input  S_BVALID, S_BID, S_BRESP, S_BUSER,
        output S_BREADY
    );

    modport slave (
        input  S_ARVALID, S_ARADDR, S_ARID, S_ARLEN, S_ARSIZE, S_ARBURST,
        input  S_ARLOCK, S_ARCACHE, S_ARPROT,
        output S_ARREADY,
        output S_RVALID, S_RDATA, S_RID, S_RRESP, S_RLAST, S_RUSER,
        input  S_RREADY,
        input  S_AWVALID, S_AWADDR, S_AWID, S_AWLEN, S_AWSIZE, S_AWBURST,
        input  S_AWLOCK, S_AWCACHE, S_AWPROT,
        output S_AWREADY,
        input  S_WVALID, S_WDATA, S_WSTRB, S_WLAST, S_WID,
        output S_WREADY,
        output S_BVALID, S_BID, S_BRESP, S_BUSER,
        input  S_BREADY
    );
endinterface

// File: rtl/axi3_slave_mem.sv
// AXI3 burst slave backed by a word-addressed memory; independent read/write FSMs.
// Ports: clk, rstn (async active-low), bus (axi3_slave_mem_if.slave).
// Option: define AXI3_SLV_WID_CHECK_EN to flag SLVERR when WID differs from AWID.
module axi3_slave_mem #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
    parameter logic [AXI_WIDTH_AD-1:0] MEM_BASE_ADDR = '0,
    parameter int MEM_DEPTH = 4096
) (
    input logic clk,
    input logic rstn,
    axi3_slave_mem_if.slave bus
);
    localparam int AD = AXI_WIDTH_AD;
    localparam int LG = $clog2(AXI_WIDTH_DS);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AD-1:0] DEPTH_W = AD'(MEM_DEPTH);
    localparam logic [AD-1:0] STEP = AD'(AXI_WIDTH_DS);

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    function automatic logic f_oor(input logic [AD-1:0] a);
        return (a < MEM_BASE_ADDR) ||
               (((a - MEM_BASE_ADDR) >> LG) >= DEPTH_W);
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [AD-1:0] a);
        return IW'((a - MEM_BASE_ADDR) >> LG);
    endfunction

    function automatic logic f_wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic f_err(input logic [2:0] size,
                                   input logic [1:0] burst,
                                   input logic [7:0] len);
        return (size != 3'(LG)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !f_wrap_ok(len));
    endfunction

    // WRAP keeps the upper address bits of the aligned window and lets
    // only the in-window offset advance.
    function automatic logic [AD-1:0] f_next(input logic [AD-1:0] a,
                                             input logic [1:0] b,
                                             input logic [7:0] len);
        logic [AD-1:0] inc;
        logic [AD-1:0] msk;
        inc = a + STEP;
        msk = ((AD'(len) + AD'(1)) << LG) - AD'(1);
        if (b == 2'b00) return a;
        if ((b == 2'b10) && f_wrap_ok(len)) return (a & ~msk) | (inc & msk);
        return inc;
    endfunction

    logic [AXI_WIDTH_DA-1:0] r_mem [MEM_DEPTH];

    rstate_t                 r_rstate;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [AXI_WIDTH_DA-1:0] r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic [AXI_WIDTH_ID-1:0] r_rid;
    logic [AD-1:0]           r_raddr;
    logic [7:0]              r_rlen;
    logic [1:0]              r_rburst;
    logic [7:0]              r_rcnt;
    logic                    r_rerr;

    wstate_t                 r_wstate;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic [AXI_WIDTH_ID-1:0] r_bid;
    logic [AD-1:0]           r_waddr;
    logic [7:0]              r_wlen;
    logic [1:0]              r_wburst;
    logic [7:0]              r_wcnt;
    logic                    r_werr;
    logic                    r_wdec;

    // The beat to present comes straight from the AR channel when idle,
    // otherwise from the running burst address.
    logic [AD-1:0]           w_rd_addr;
    logic                    w_rd_err;
    logic                    w_rd_oor;
    logic [AXI_WIDTH_DA-1:0] w_rd_word;
    logic [1:0]              w_rd_resp;

    always_comb begin
        w_rd_addr = r_raddr;
        w_rd_err  = r_rerr;
        if (r_rstate == R_IDLE) begin
            w_rd_addr = bus.S_ARADDR;
            w_rd_err  = f_err(bus.S_ARSIZE, bus.S_ARBURST, bus.S_ARLEN);
        end
        w_rd_oor  = f_oor(w_rd_addr);
        w_rd_word = w_rd_oor ? '0 : r_mem[f_idx(w_rd_addr)];
        w_rd_resp = w_rd_oor ? 2'b11 : (w_rd_err ? 2'b10 : 2'b00);
    end

    logic          w_wbeat;
    logic          w_wr_oor;
    logic [IW-1:0] w_wr_idx;
    logic          w_wr_last;
    logic          w_wid_bad;
    logic          w_wr_err_n;
    logic          w_wr_dec_n;

`ifdef AXI3_SLV_WID_CHECK_EN
    assign w_wid_bad = (bus.S_WID != r_bid);
`else
    assign w_wid_bad = 1'b0;
`endif

    assign w_wbeat    = r_wready & bus.S_WVALID;
    assign w_wr_oor   = f_oor(r_waddr);
    assign w_wr_idx   = f_idx(r_waddr);
    assign w_wr_last  = (r_wcnt == r_wlen);
    assign w_wr_err_n = r_werr | (bus.S_WLAST != w_wr_last) | w_wid_bad;
    assign w_wr_dec_n = r_wdec | w_wr_oor;

    always_ff @(posedge clk) begin
        if (w_wbeat && !w_wr_oor) begin
            for (int b = 0; b < AXI_WIDTH_DS; b++) begin
                if (bus.S_WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= bus.S_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rburst  <= 2'b00;
            r_rcnt    <= '0;
            r_rerr    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (bus.S_ARVALID) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= bus.S_ARID;
                        r_rlen    <= bus.S_ARLEN;
                        r_rburst  <= bus.S_ARBURST;
                        r_rerr    <= w_rd_err;
                        r_rcnt    <= '0;
                        r_rlast   <= (bus.S_ARLEN == 8'd0);
                        r_rdata   <= w_rd_word;
                        r_rresp   <= w_rd_resp;
                        r_raddr   <= f_next(bus.S_ARADDR, bus.S_ARBURST, bus.S_ARLEN);
                    end
                end
                R_DATA: begin
                    if (bus.S_RREADY) begin
                        if (r_rlast) begin
                            r_rstate  <= R_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                            r_rdata <= w_rd_word;
                            r_rresp <= w_rd_resp;
                            r_raddr <= f_next(r_raddr, r_rburst, r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wburst  <= 2'b00;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wdec    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (bus.S_AWVALID) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= bus.S_AWID;
                        r_waddr   <= bus.S_AWADDR;
                        r_wlen    <= bus.S_AWLEN;
                        r_wburst  <= bus.S_AWBURST;
                        r_werr    <= f_err(bus.S_AWSIZE, bus.S_AWBURST, bus.S_AWLEN);
                        r_wdec    <= 1'b0;
                        r_wcnt    <= '0;
                    end
                end
                W_DATA: begin
                    if (bus.S_WVALID) begin
                        r_werr  <= w_wr_err_n;
                        r_wdec  <= w_wr_dec_n;
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_waddr <= f_next(r_waddr, r_wburst, r_wlen);
                        // Beat count, not WLAST, closes the burst.
                        if (w_wr_last) begin
                            r_wstate <= W_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_wr_dec_n ? 2'b11 :
                                        (w_wr_err_n ? 2'b10 : 2'b00);
                        end
                    end
                end
                W_RESP: begin
                    if (bus.S_BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign bus.S_ARREADY = r_arready;
    assign bus.S_RVALID  = r_rvalid;
    assign bus.S_RDATA   = r_rdata;
    assign bus.S_RRESP   = r_rresp;
    assign bus.S_RLAST   = r_rlast;
    assign bus.S_RID     = r_rid;
    assign bus.S_RUSER   = 1'b0;
    assign bus.S_AWREADY = r_awready;
    assign bus.S_WREADY  = r_wready;
    assign bus.S_BVALID  = r_bvalid;
    assign bus.S_BRESP   = r_bresp;
    assign bus.S_BID     = r_bid;
    assign bus.S_BUSER   = 1'b0;

    logic w_unused;
`ifdef AXI3_SLV_WID_CHECK_EN
    assign w_unused = ^{bus.S_ARLOCK, bus.S_ARCACHE, bus.S_ARPROT,
                        bus.S_AWLOCK, bus.S_AWCACHE, bus.S_AWPROT};
`else
    assign w_unused = ^{bus.S_ARLOCK, bus.S_ARCACHE, bus.S_ARPROT,
                        bus.S_AWLOCK, bus.S_AWCACHE, bus.S_AWPROT, bus.S_WID};
`endif
endmodule
